// File: rtl/seq_bcd_mult_ctrl_pkg.sv
// Shared types and constants for the sequential binary multiplier with
// double-dabble binary-to-BCD conversion of the product.
package seq_bcd_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MULT_CYCLES = 8;
    localparam int CONV_CYCLES = 16;

    localparam int OPND_W     = 8;
    localparam int PROD_W     = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DD_W       = BCD_W + PROD_W;
    localparam int CNT_W      = 5;

endpackage

// File: rtl/seq_bcd_mult_ctrl_if.sv
// Handshake and data bundle between a requester and the multiplier.
interface seq_bcd_mult_ctrl_if;
    import seq_bcd_mult_ctrl_pkg::*;

    logic              start;
    logic [OPND_W-1:0] a_hex;
    logic [OPND_W-1:0] b_hex;
    logic              ack;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] op_hex;
    logic [BCD_W-1:0]  op_dec;

    modport master (
        output start, a_hex, b_hex, ack,
        input  busy, done, op_hex, op_dec
    );

    modport slave (
        input  start, a_hex, b_hex, ack,
        output busy, done, op_hex, op_dec
    );

endinterface

// File: rtl/seq_bcd_mult_ctrl_dd_add3.sv
// One BCD digit correction step of double-dabble: add 3 when digit >= 5.
module dd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/seq_bcd_mult_ctrl.sv
// Sequential 8x8 shift-add multiplier followed by a 16-cycle double-dabble
// conversion. The result is presented as both binary and 5-digit packed BCD
// and held until acknowledged; outputs persist until the next result.
module seq_bcd_mult_ctrl
    import seq_bcd_mult_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_bcd_mult_ctrl_if.slave   mult_bus
);

    localparam logic [CNT_W-1:0] LAST_MULT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CONV = CNT_W'(CONV_CYCLES - 1);

    state_t              state_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [PROD_W-1:0]   mcand_reg;
    logic [OPND_W-1:0]   mplier_reg;
    logic [PROD_W-1:0]   acc_reg;
    logic [DD_W-1:0]     dd_reg;
    logic [PROD_W-1:0]   op_hex_reg;
    logic [BCD_W-1:0]    op_dec_reg;

    logic [PROD_W-1:0]   acc_next;
    logic [BCD_W-1:0]    bcd_adj;
    logic [DD_W-1:0]     dd_shift;

    // Accumulator value after the current shift-add step (LSB of multiplier first).
    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    // Per-digit +3 correction on the BCD half of the double-dabble register.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dd_digit
            dd_add3 u_dd_add3 (
                .din  (dd_reg[PROD_W + 4*gi +: 4]),
                .dout (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Corrected digits and remaining binary bits shift left together by one.
    assign dd_shift = {bcd_adj, dd_reg[PROD_W-1:0]} << 1;

    // Control FSM with datapath registers; one counter is reused by MULT and CONV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            dd_reg     <= '0;
            op_hex_reg <= '0;
            op_dec_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mult_bus.start) begin
                        mcand_reg  <= {{(PROD_W-OPND_W){1'b0}}, mult_bus.a_hex};
                        mplier_reg <= mult_bus.b_hex;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= MULT;
                    end
                end
                MULT: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (cnt_reg == LAST_MULT) begin
                        // Seed conversion with the final product, including this cycle's add.
                        cnt_reg   <= '0;
                        dd_reg    <= {{BCD_W{1'b0}}, acc_next};
                        state_reg <= CONV;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CONV: begin
                    dd_reg <= dd_shift;
                    if (cnt_reg == LAST_CONV) begin
                        // Both result views update on the same edge that raises done.
                        op_hex_reg <= acc_reg;
                        op_dec_reg <= dd_shift[DD_W-1:PROD_W];
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (mult_bus.ack) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mult_bus.busy   = busy_reg;
    assign mult_bus.done   = done_reg;
    assign mult_bus.op_hex = op_hex_reg;
    assign mult_bus.op_dec = op_dec_reg;

endmodule

// File: tb/tb_seq_bcd_mult_ctrl.sv
// Scoreboard bench for seq_bcd_mult_ctrl: stimulus pushes hand-computed
// results, a monitor pops and compares on every rising edge of done.
module tb_seq_bcd_mult_ctrl;

    logic clk;
    logic rst;

    seq_bcd_mult_ctrl_if bus ();

    seq_bcd_mult_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .mult_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hex;
        logic [19:0] dec;
        int          accept;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every new done pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1 && prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with empty scoreboard at cycle %0d", cycle_cnt);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_op_hex"}, 32'(bus.op_hex), 32'(e.hex));
                    check({e.name, "_op_dec"}, 32'(bus.op_dec), 32'(e.dec));
                    check({e.name, "_latency"}, 32'(cycle_cnt - e.accept), 32'd24);
                    check({e.name, "_busy_low"}, 32'(bus.busy), 32'd0);
                    $display("txn %s: op_hex=0x%04h op_dec=0x%05h latency=%0d",
                             e.name, bus.op_hex, bus.op_dec, cycle_cnt - e.accept);
                end
            end
            prev = bus.done;
        end
    end

    // Present operands with a one-cycle start pulse; optionally expect a result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit push,
                         input logic [15:0] hex, input logic [19:0] dec, input string name);
        @(negedge clk);
        bus.a_hex = a;
        bus.b_hex = b;
        bus.start = 1'b1;
        if (push) sb.push_back('{hex: hex, dec: dec, accept: cycle_cnt + 1, name: name});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 required done=1 within 40 cycles", name);
        end
    endtask

    task automatic ack_it(input string name);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_idle_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bit          saw_busy;
        logic [15:0] hold_hex;
        logic [19:0] hold_dec;

        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.a_hex = '0;
        bus.b_hex = '0;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_op_hex", 32'(bus.op_hex), 32'd0);
        check("rst_op_dec", 32'(bus.op_dec), 32'd0);
        rst = 1'b0;

        // Basic product and acknowledge
        issue(8'h23, 8'h02, 1'b1, 16'h0046, 20'h00070, "m23x02");
        wait_done("m23x02");
        ack_it("m23x02");

        // Back-to-back operations; the first result persists until the second DONE
        issue(8'h25, 8'h08, 1'b1, 16'h0128, 20'h00296, "m25x08");
        wait_done("m25x08");
        ack_it("m25x08");
        issue(8'h11, 8'h10, 1'b1, 16'h0110, 20'h00272, "m11x10");
        check("hold_mult_hex", 32'(bus.op_hex), 32'h0128);
        check("hold_mult_dec", 32'(bus.op_dec), 32'h00296);
        repeat (12) @(negedge clk);
        check("hold_conv_hex", 32'(bus.op_hex), 32'h0128);
        check("hold_conv_dec", 32'(bus.op_dec), 32'h00296);
        wait_done("m11x10");
        ack_it("m11x10");

        // Extremes: largest product and a zero operand
        issue(8'hFF, 8'hFF, 1'b1, 16'hFE01, 20'h65025, "mFFxFF");
        wait_done("mFFxFF");
        ack_it("mFFxFF");
        issue(8'h00, 8'h7B, 1'b1, 16'h0000, 20'h00000, "m00x7B");
        wait_done("m00x7B");
        ack_it("m00x7B");

        // Operand changes and start pulses while busy are ignored
        issue(8'h0C, 8'h0D, 1'b1, 16'h009C, 20'h00156, "m0Cx0D");
        repeat (3) @(negedge clk);
        bus.a_hex = 8'h99;
        bus.b_hex = 8'h77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("m0Cx0D");
        ack_it("m0Cx0D");
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
        end
        check("no_queued_start", 32'(saw_busy), 32'd0);

        // Asynchronous reset in the middle of MULT
        issue(8'h44, 8'h44, 1'b0, 16'h0000, 20'h00000, "m44x44");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_op_hex", 32'(bus.op_hex), 32'd0);
        check("midrst_op_dec", 32'(bus.op_dec), 32'd0);
        check("midrst_busy",   32'(bus.busy),   32'd0);
        check("midrst_done",   32'(bus.done),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h32, 8'h05, 1'b1, 16'h00FA, 20'h00250, "m32x05");
        wait_done("m32x05");
        ack_it("m32x05");

        // DONE holds without ack; start+ack together returns to IDLE only
        issue(8'h64, 8'h0A, 1'b1, 16'h03E8, 20'h01000, "m64x0A");
        wait_done("m64x0A");
        hold_hex = bus.op_hex;
        hold_dec = bus.op_dec;
        repeat (10) @(negedge clk);
        check("ackwait_done",   32'(bus.done),   32'd1);
        check("ackwait_op_hex", 32'(bus.op_hex), 32'h03E8);
        check("ackwait_op_dec", 32'(bus.op_dec), 32'h01000);
        check("ackwait_stable", 32'((bus.op_hex === hold_hex) && (bus.op_dec === hold_dec)), 32'd1);
        bus.a_hex = 8'h05;
        bus.b_hex = 8'h05;
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        check("startack_busy", 32'(bus.busy), 32'd0);
        check("startack_done", 32'(bus.done), 32'd0);
        saw_busy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
        end
        check("startack_no_op", 32'(saw_busy), 32'd0);
        check("startack_op_hex", 32'(bus.op_hex), 32'h03E8);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
